// File: rtl/clk_div.sv
// Programmable glitch-free integer clock divider: clk_o = clk_i / D, D changeable at run time.
// Latency: en_i sampled high -> clk_o high on that same posedge; ratio writes in RUN apply at the next period boundary.
// Backpressure: div_ready_o drops while a ratio write is pending and rises again once the boundary consumes it.
//
// Ports:
//   clk_i        source clock, all flops on posedge
//   arst_ni      asynchronous reset, active low
//   en_i         run request (sampled only in IDLE or at a period boundary)
//   div_i        requested divide ratio, values below 2 are stored as 2
//   div_valid_i  ratio write request
//   div_ready_o  ratio write can be accepted (no write pending)
//   div_ack_o    one-cycle pulse during the first cycle at the new ratio
//   active_o     divider is in RUN
//   clk_o        divided clock, straight from a flop
module clk_div #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 div_ack_o,
  output logic                 active_o,
  output logic                 clk_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  state_e               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_cur_div;
  logic [DIV_WIDTH-1:0] r_pend_div;
  logic                 r_pend;
  logic                 r_clk;
  logic                 r_active;
  logic                 r_ack;

  state_e               w_state_nxt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_cur_div_nxt;
  logic [DIV_WIDTH-1:0] w_pend_div_nxt;
  logic                 w_pend_nxt;
  logic                 w_clk_nxt;
  logic                 w_active_nxt;
  logic                 w_ack_nxt;

  logic                 w_xfer;
  logic [DIV_WIDTH-1:0] w_div_wr;
  logic [DIV_WIDTH-1:0] w_half;
  logic [DIV_WIDTH-1:0] w_cnt_inc;
  logic                 w_bnd;

  assign w_xfer    = div_valid_i & ~r_pend;
  assign w_div_wr  = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign w_half    = r_cur_div >> 1;
  // cur_div >= 2 always, so cnt+1 never wraps and cur_div-1 never underflows
  assign w_cnt_inc = r_cnt + ONE;
  assign w_bnd     = (r_cnt == (r_cur_div - ONE));

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cur_div_nxt  = r_cur_div;
    w_pend_div_nxt = r_pend_div;
    w_pend_nxt     = r_pend;
    w_clk_nxt      = r_clk;
    w_active_nxt   = r_active;
    w_ack_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // no clock running, so a new ratio can be taken on the spot
        if (w_xfer) begin
          w_cur_div_nxt = w_div_wr;
          w_ack_nxt     = 1'b1;
        end
        if (en_i) begin
          w_state_nxt  = ST_RUN;
          w_cnt_nxt    = '0;
          w_clk_nxt    = 1'b1;
          w_active_nxt = 1'b1;
        end
      end

      ST_RUN: begin
        // pend is evaluated from its old value at the boundary, so a write
        // accepted on a boundary edge waits for the following boundary
        if (w_xfer) begin
          w_pend_div_nxt = w_div_wr;
          w_pend_nxt     = 1'b1;
        end
        if (w_bnd) begin
          if (r_pend) begin
            w_cur_div_nxt = r_pend_div;
            w_pend_nxt    = 1'b0;
            w_ack_nxt     = 1'b1;
          end
          w_cnt_nxt = '0;
          if (en_i) begin
            w_clk_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_clk_nxt    = 1'b0;
            w_active_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          // high for the first floor(D/2) cycles of the period
          w_clk_nxt = (w_cnt_inc < w_half);
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = '0;
        w_clk_nxt    = 1'b0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cur_div  <= DIV_RST;
      r_pend_div <= DIV_RST;
      r_pend     <= 1'b0;
      r_clk      <= 1'b0;
      r_active   <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_div  <= w_cur_div_nxt;
      r_pend_div <= w_pend_div_nxt;
      r_pend     <= w_pend_nxt;
      r_clk      <= w_clk_nxt;
      r_active   <= w_active_nxt;
      r_ack      <= w_ack_nxt;
    end
  end

  assign div_ready_o = ~r_pend;
  assign div_ack_o   = r_ack;
  assign active_o    = r_active;
  assign clk_o       = r_clk;

endmodule

// File: tb/tb_clk_div.sv
module tb_clk_div;

  logic       clk_i;
  logic       arst_ni;
  logic       en_i;
  logic [7:0] div_i;
  logic       div_valid_i;
  logic       div_ready_o;
  logic       div_ack_o;
  logic       active_o;
  logic       clk_o;

  int checks = 0;
  int errors = 0;

  clk_div #(
    .DIV_WIDTH(8),
    .RESET_DIV(2)
  ) dut (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o),
    .div_ack_o  (div_ack_o),
    .active_o   (active_o),
    .clk_o      (clk_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] div;
    logic [3:0] exp; // {clk_o, active_o, div_ready_o, div_ack_o}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic vld, input logic [7:0] div,
                              input logic c, input logic a, input logic r, input logic k);
    vec_t v;
    v.en  = en;
    v.vld = vld;
    v.div = div;
    v.exp = {c, a, r, k};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] exp);
    logic [3:0] act;
    act = {clk_o, active_o, div_ready_o, div_ack_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {clk,active,ready,ack} got %b expected %b", nm, act, exp);
    end
  endtask

  // inputs change 1 time unit after a posedge; outputs are read at the same point
  task automatic tick(input logic en, input logic vld, input logic [7:0] div);
    en_i        = en;
    div_valid_i = vld;
    div_i       = div;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ack(input string nm, input int bound);
    bit got;
    got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      tick(1'b1, 1'b0, 8'd0);
      if (div_ack_o === 1'b1) got = 1'b1;
    end
    chk(nm, int'(got), 1);
  endtask

  initial begin
    int hi;

    // directed table, starting from reset at D=2
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0)); // enable: first edge high
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0));
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0));
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,   0, 0, 1, 0)); // boundary with en low -> IDLE
    vq.push_back(mk(0, 1, 5,   0, 0, 1, 1)); // IDLE write 5, ack next cycle
    vq.push_back(mk(0, 0, 0,   0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0)); // D=5: cnt0 high
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0)); // cnt1 high
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0)); // cnt2 low
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0)); // cnt3
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0)); // cnt4
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0)); // cnt0 second period
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0));
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,   0, 1, 1, 0)); // en dropped mid-period: keeps running
    vq.push_back(mk(0, 0, 0,   0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,   0, 0, 1, 0)); // boundary -> IDLE
    vq.push_back(mk(0, 0, 0,   0, 0, 1, 0));
    vq.push_back(mk(0, 1, 0,   0, 0, 1, 1)); // write 0 -> stored as 2
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0));
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0));
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0));
    vq.push_back(mk(0, 1, 1,   0, 1, 0, 0)); // RUN write 1 while dropping en: pending
    vq.push_back(mk(0, 0, 0,   0, 0, 1, 1)); // boundary: update + ack + IDLE together
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0)); // D=2 (1 clamped)
    vq.push_back(mk(1, 0, 0,   0, 1, 1, 0));
    vq.push_back(mk(1, 0, 0,   1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,   0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,   0, 0, 1, 0)); // back to IDLE

    arst_ni     = 1'b0;
    en_i        = 1'b0;
    div_valid_i = 1'b0;
    div_i       = 8'd0;
    #2;
    chk_outs("reset_state", 4'b0010);
    #10;
    arst_ni = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].en, vq[i].vld, vq[i].div);
      chk_outs($sformatf("vec%0d", i), vq[i].exp);
    end

    // D=4, write 7 sampled at cnt=1, second write held off
    tick(0, 1, 8'd4);
    chk_outs("d4_wr_ack", 4'b0011);
    tick(1, 0, 8'd0);
    chk_outs("d4_cnt0", 4'b1110);
    tick(1, 0, 8'd0);
    chk_outs("d4_cnt1", 4'b1110);
    tick(1, 1, 8'd7);
    chk_outs("d4_wr7_cnt2", 4'b0100);
    tick(1, 1, 8'd3);
    chk_outs("d4_wr3_held_cnt3", 4'b0100);
    tick(1, 0, 8'd0);
    chk_outs("d7_first_ack", 4'b1111);
    for (int p = 0; p < 2; p++) begin
      hi = 1;
      for (int i = 1; i < 7; i++) begin
        tick(1, 0, 8'd0);
        chk($sformatf("d7_p%0d_cnt%0d_clk", p, i), int'(clk_o), (i < 3) ? 1 : 0);
        if (clk_o === 1'b1) hi++;
      end
      chk($sformatf("d7_p%0d_high", p), hi, 3);
      tick(1, 0, 8'd0);
      chk_outs($sformatf("d7_p%0d_wrap", p), 4'b1110);
    end

    // D=6, drop en at cnt=1: period completes high 3 / low 3
    tick(1, 1, 8'd6);
    chk("d6_wr_ready", int'(div_ready_o), 0);
    wait_ack("d6_ack_seen", 20);
    chk_outs("d6_cnt0", 4'b1111);
    tick(1, 0, 8'd0);
    chk_outs("d6_cnt1", 4'b1110);
    tick(0, 0, 8'd0);
    chk_outs("d6_cnt2", 4'b1110);
    for (int i = 3; i < 6; i++) begin
      tick(0, 0, 8'd0);
      chk_outs($sformatf("d6_cnt%0d", i), 4'b0110);
    end
    tick(0, 0, 8'd0);
    chk_outs("d6_idle", 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 8'd0);
      chk_outs($sformatf("d6_idle_hold%0d", i), 4'b0010);
    end

    // D=255: period 255, high 127
    tick(0, 1, 8'd255);
    chk_outs("d255_wr_ack", 4'b0011);
    tick(1, 0, 8'd0);
    chk_outs("d255_cnt0", 4'b1110);
    hi = 1;
    for (int i = 1; i < 255; i++) begin
      tick(1, 0, 8'd0);
      if (clk_o === 1'b1) hi++;
    end
    chk("d255_high", hi, 127);
    chk("d255_cnt254_clk", int'(clk_o), 0);
    tick(1, 0, 8'd0);
    chk_outs("d255_wrap", 4'b1110);

    // switch to D=8, then reset mid-period
    tick(1, 1, 8'd8);
    wait_ack("d8_ack_seen", 300);
    tick(1, 0, 8'd0);
    tick(1, 0, 8'd0);
    chk_outs("d8_cnt2", 4'b1110);
    #3;
    arst_ni = 1'b0;
    #1;
    chk_outs("arst_immediate", 4'b0010);
    @(posedge clk_i);
    #1;
    chk_outs("arst_held", 4'b0010);
    #3;
    arst_ni = 1'b1;
    tick(1, 0, 8'd0);
    chk_outs("restart_cnt0", 4'b1110);
    tick(1, 0, 8'd0);
    chk_outs("restart_cnt1", 4'b0110);
    tick(1, 0, 8'd0);
    chk_outs("restart_d2_wrap", 4'b1110);
    tick(0, 0, 8'd0);
    tick(0, 0, 8'd0);
    chk_outs("restart_idle", 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
